// File: rtl/core_pwr_pkg.sv
// Shared types and defaults for the core power controller.
// State encodings are visible on state_o and must stay stable.
package core_pwr_pkg;

  localparam int DEF_NUM_IRQ      = 32;
  localparam int DEF_IDLE_CYCLES  = 4;
  localparam int DEF_WAKE_CYCLES  = 2;
  localparam int DEF_LOCK_TIMEOUT = 1024;

  typedef enum logic [2:0] {
    ST_BOOT  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_SLEEP = 3'd3,
    ST_WAKE  = 3'd4
  } pwr_state_e;

  // One shared counter must hold the largest terminal count of any state.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/core_pwr_ctrl.sv
// Core fetch/clock-enable sequencer: FLL lock wait, drain-then-gate on sleep
// request, ungate on any unmasked interrupt.
//
// state | meaning
// BOOT  | clock on, fetch off, waiting for FLL lock or lock timeout
// RUN   | core running, fetch follows the pad fetch enable
// DRAIN | fetch off, counting consecutive idle cycles before gating
// SLEEP | core clock gated, waiting for an unmasked interrupt
// WAKE  | clock running again, fetch held off while the core settles
module core_pwr_ctrl
  import core_pwr_pkg::*;
#(
  parameter int NUM_IRQ      = DEF_NUM_IRQ,
  parameter int IDLE_CYCLES  = DEF_IDLE_CYCLES,
  parameter int WAKE_CYCLES  = DEF_WAKE_CYCLES,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_enable_i,
  input  logic               fll_lock_i,
  input  logic               sleep_req_i,
  input  logic               core_busy_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [NUM_IRQ-1:0] irq_mask_i,
  output logic               fetch_enable_o,
  output logic               core_clk_en_o,
  output logic               sleep_ack_o,
  output logic               wake_o,
  output logic               lock_timeout_o,
  output logic [2:0]         state_o
);

  localparam int CW = cnt_width(LOCK_TIMEOUT, IDLE_CYCLES, WAKE_CYCLES);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_CYCLES - 1);
  localparam logic [CW-1:0] WAKE_LAST = CW'(WAKE_CYCLES - 1);

  pwr_state_e    r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic          w_wake_pend, w_timeout_set;
  logic          r_fetch_en, r_clk_en, r_sleep_ack, r_wake, r_lock_timeout;

  assign w_wake_pend = |(irq_i & irq_mask_i);
  assign w_cnt_inc   = (r_cnt == '1) ? r_cnt : r_cnt + CW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_BOOT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_timeout_set = 1'b0;
    case (r_state)
      ST_BOOT: begin
        if (fll_lock_i) begin
          w_state_nxt = ST_RUN;
        end else if (r_cnt == LOCK_LAST) begin
          w_state_nxt   = ST_RUN;
          w_timeout_set = 1'b1;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      ST_RUN: begin
        if (sleep_req_i && fetch_enable_i) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        // An abort or wake must win over a gate completing in the same cycle.
        if (w_wake_pend || !sleep_req_i) begin
          w_state_nxt = ST_RUN;
        end else if (core_busy_i) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == IDLE_LAST) begin
          w_state_nxt = ST_SLEEP;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      ST_SLEEP: begin
        if (w_wake_pend) w_state_nxt = ST_WAKE;
      end
      ST_WAKE: begin
        if (r_cnt == WAKE_LAST) w_state_nxt = ST_RUN;
        else w_cnt_nxt = w_cnt_inc;
      end
      default: w_state_nxt = ST_BOOT;
    endcase
    if (w_state_nxt != r_state) w_cnt_nxt = '0;
  end

  // Outputs are registered from the next state so they line up with state_o.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_en     <= 1'b0;
      r_clk_en       <= 1'b1;
      r_sleep_ack    <= 1'b0;
      r_wake         <= 1'b0;
      r_lock_timeout <= 1'b0;
    end else begin
      r_fetch_en     <= (w_state_nxt == ST_RUN) && fetch_enable_i;
      r_clk_en       <= (w_state_nxt != ST_SLEEP);
      r_sleep_ack    <= (r_state == ST_DRAIN) && (w_state_nxt == ST_SLEEP);
      r_wake         <= (r_state == ST_SLEEP) && (w_state_nxt == ST_WAKE);
      r_lock_timeout <= r_lock_timeout | w_timeout_set;
    end
  end

  assign fetch_enable_o = r_fetch_en;
  assign core_clk_en_o  = r_clk_en;
  assign sleep_ack_o    = r_sleep_ack;
  assign wake_o         = r_wake;
  assign lock_timeout_o = r_lock_timeout;
  assign state_o        = r_state;

endmodule

// File: tb/tb_core_pwr_ctrl.sv
// Self-checking bench for core_pwr_ctrl: vector table, hand sequences for
// boot/timeout/async reset, and a randomized run against a cycle-count model.
module tb_core_pwr_ctrl;

  localparam int NIRQ  = 32;
  localparam int IDLE  = 4;
  localparam int WAKEC = 2;
  localparam int LOCKT = 1024;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            fetch_enable_i, fll_lock_i, sleep_req_i, core_busy_i;
  logic [NIRQ-1:0] irq_i, irq_mask_i;
  logic            fetch_enable_o, core_clk_en_o, sleep_ack_o, wake_o, lock_timeout_o;
  logic [2:0]      state_o;

  always #5 clk = ~clk;

  core_pwr_ctrl #(
    .NUM_IRQ(NIRQ), .IDLE_CYCLES(IDLE), .WAKE_CYCLES(WAKEC), .LOCK_TIMEOUT(LOCKT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_enable_i(fetch_enable_i), .fll_lock_i(fll_lock_i),
    .sleep_req_i(sleep_req_i), .core_busy_i(core_busy_i),
    .irq_i(irq_i), .irq_mask_i(irq_mask_i),
    .fetch_enable_o(fetch_enable_o), .core_clk_en_o(core_clk_en_o),
    .sleep_ack_o(sleep_ack_o), .wake_o(wake_o),
    .lock_timeout_o(lock_timeout_o), .state_o(state_o)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: phase plus elapsed-cycle tallies per phase.
  localparam int P_BOOT = 0, P_RUN = 1, P_DRAIN = 2, P_SLEEP = 3, P_WAKE = 4;
  int m_phase, m_boot_age, m_idle_streak, m_wake_age;
  bit m_to, m_fe, m_ce, m_ack, m_wk;

  task automatic model_reset();
    m_phase = P_BOOT; m_boot_age = 0; m_idle_streak = 0; m_wake_age = 0;
    m_to = 0; m_fe = 0; m_ce = 1; m_ack = 0; m_wk = 0;
  endtask

  task automatic model_step();
    bit wp;
    wp    = ((irq_i & irq_mask_i) != '0);
    m_ack = 0;
    m_wk  = 0;
    case (m_phase)
      P_BOOT: begin
        m_boot_age++;
        if (fll_lock_i) m_phase = P_RUN;
        else if (m_boot_age == LOCKT) begin m_phase = P_RUN; m_to = 1; end
      end
      P_RUN: if (sleep_req_i && fetch_enable_i) begin m_phase = P_DRAIN; m_idle_streak = 0; end
      P_DRAIN: begin
        if (wp || !sleep_req_i) m_phase = P_RUN;
        else if (core_busy_i) m_idle_streak = 0;
        else begin
          m_idle_streak++;
          if (m_idle_streak == IDLE) begin m_phase = P_SLEEP; m_ack = 1; end
        end
      end
      P_SLEEP: if (wp) begin m_phase = P_WAKE; m_wk = 1; m_wake_age = 0; end
      default: begin
        m_wake_age++;
        if (m_wake_age == WAKEC) m_phase = P_RUN;
      end
    endcase
    m_fe = (m_phase == P_RUN) && fetch_enable_i;
    m_ce = (m_phase != P_SLEEP);
  endtask

  task automatic model_check();
    logic [2:0] ps;
    ps = m_phase[2:0];
    n_tests++;
    if (state_o !== ps || fetch_enable_o !== m_fe || core_clk_en_o !== m_ce ||
        sleep_ack_o !== m_ack || wake_o !== m_wk || lock_timeout_o !== m_to) begin
      n_fail++;
      if (n_fail < 30)
        $display("FAIL model cyc=%0d got st=%0d fe=%b ce=%b ack=%b wk=%b to=%b required st=%0d fe=%b ce=%b ack=%b wk=%b to=%b",
                 cyc, state_o, fetch_enable_o, core_clk_en_o, sleep_ack_o, wake_o, lock_timeout_o,
                 ps, m_fe, m_ce, m_ack, m_wk, m_to);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    model_check();
  endtask

  task automatic check1(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    bit fe, sleep, busy, irq5, mask5;
    int st;
    bit fo, ce, ack, wk;
  } vec_t;

  vec_t vt[$];

  initial begin
    fetch_enable_i = 1; fll_lock_i = 0; sleep_req_i = 0; core_busy_i = 0;
    irq_i = '0; irq_mask_i = '0;
    rst_n = 1'b0;
    model_reset();
    #12;
    check1("reset_state", {26'd0, state_o, fetch_enable_o, core_clk_en_o, sleep_ack_o, wake_o, lock_timeout_o},
           {26'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    apply_reset();

    // Boot with lock rising on the 10th cycle after release.
    repeat (9) tick();
    check1("boot_wait_state", state_o, 0);
    fll_lock_i = 1;
    tick();
    check1("boot_lock_state", state_o, 1);
    tick();
    check1("boot_fetch_en", fetch_enable_o, 1);
    check1("boot_no_timeout", lock_timeout_o, 0);

    //          fe sl bz ir mk  st fo ce ak wk
    vt.push_back('{1, 1, 0, 0, 0, 2, 0, 1, 0, 0});
    vt.push_back('{1, 1, 0, 0, 0, 2, 0, 1, 0, 0});
    vt.push_back('{1, 1, 1, 0, 0, 2, 0, 1, 0, 0});
    vt.push_back('{1, 1, 0, 0, 0, 2, 0, 1, 0, 0});
    vt.push_back('{1, 1, 0, 0, 0, 2, 0, 1, 0, 0});
    vt.push_back('{1, 1, 0, 0, 0, 2, 0, 1, 0, 0});
    vt.push_back('{1, 1, 0, 0, 0, 3, 0, 0, 1, 0});
    vt.push_back('{1, 0, 0, 1, 0, 3, 0, 0, 0, 0});
    vt.push_back('{0, 0, 0, 0, 1, 3, 0, 0, 0, 0});
    vt.push_back('{1, 0, 0, 1, 1, 4, 0, 1, 0, 1});
    vt.push_back('{1, 0, 0, 0, 1, 4, 0, 1, 0, 0});
    vt.push_back('{1, 0, 0, 0, 1, 1, 1, 1, 0, 0});
    vt.push_back('{1, 0, 0, 0, 1, 1, 1, 1, 0, 0});
    vt.push_back('{1, 1, 0, 0, 1, 2, 0, 1, 0, 0});
    vt.push_back('{1, 1, 0, 1, 1, 1, 1, 1, 0, 0});
    vt.push_back('{1, 1, 0, 0, 1, 2, 0, 1, 0, 0});
    vt.push_back('{1, 0, 0, 0, 1, 1, 1, 1, 0, 0});
    vt.push_back('{0, 1, 0, 0, 1, 1, 0, 1, 0, 0});
    vt.push_back('{1, 0, 0, 0, 1, 1, 1, 1, 0, 0});
    vt.push_back('{1, 1, 0, 0, 1, 2, 0, 1, 0, 0});
    vt.push_back('{1, 1, 0, 0, 1, 2, 0, 1, 0, 0});
    vt.push_back('{1, 1, 0, 0, 1, 2, 0, 1, 0, 0});
    vt.push_back('{1, 1, 0, 0, 1, 2, 0, 1, 0, 0});
    vt.push_back('{1, 1, 0, 1, 1, 1, 1, 1, 0, 0});
    vt.push_back('{1, 0, 0, 0, 1, 1, 1, 1, 0, 0});

    foreach (vt[i]) begin
      logic [2:0] es;
      fetch_enable_i = vt[i].fe;
      sleep_req_i    = vt[i].sleep;
      core_busy_i    = vt[i].busy;
      irq_i          = vt[i].irq5 ? 32'h20 : 32'h0;
      irq_mask_i     = vt[i].mask5 ? 32'hFFFF_FFFF : 32'hFFFF_FFDF;
      tick();
      es = vt[i].st[2:0];
      n_tests++;
      if (state_o !== es || fetch_enable_o !== vt[i].fo || core_clk_en_o !== vt[i].ce ||
          sleep_ack_o !== vt[i].ack || wake_o !== vt[i].wk) begin
        n_fail++;
        $display("FAIL vec[%0d] got st=%0d fe=%b ce=%b ack=%b wk=%b required st=%0d fe=%b ce=%b ack=%b wk=%b",
                 i, state_o, fetch_enable_o, core_clk_en_o, sleep_ack_o, wake_o,
                 es, vt[i].fo, vt[i].ce, vt[i].ack, vt[i].wk);
      end
    end

    // Reach SLEEP, then assert reset between clock edges.
    irq_i = '0; sleep_req_i = 1; core_busy_i = 0; fetch_enable_i = 1;
    repeat (5) tick();
    check1("sleep_reached", state_o, 3);
    check1("sleep_clk_gated", core_clk_en_o, 0);
    sleep_req_i = 0;
    tick();
    check1("sleep_req_ignored", state_o, 3);
    rst_n = 1'b0;
    #2;
    check1("async_rst_state", state_o, 0);
    check1("async_rst_clk_en", core_clk_en_o, 1);
    check1("async_rst_fetch", fetch_enable_o, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Lock never arrives: RUN on the 1024th cycle with the sticky flag.
    fll_lock_i = 0;
    repeat (LOCKT - 1) tick();
    check1("timeout_pre_state", state_o, 0);
    check1("timeout_pre_flag", lock_timeout_o, 0);
    tick();
    check1("timeout_state", state_o, 1);
    check1("timeout_flag", lock_timeout_o, 1);
    for (int k = 0; k < 6; k++) begin
      fll_lock_i = k[0];
      tick();
    end
    check1("timeout_sticky", lock_timeout_o, 1);
    apply_reset();
    check1("timeout_cleared", lock_timeout_o, 0);

    // Lock arriving on the terminal cycle beats the timeout.
    fll_lock_i = 0;
    repeat (LOCKT - 1) tick();
    fll_lock_i = 1;
    tick();
    check1("lock_vs_to_state", state_o, 1);
    check1("lock_vs_to_flag", lock_timeout_o, 0);

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      fetch_enable_i = ($urandom_range(7) != 0);
      if ($urandom_range(5) == 0) sleep_req_i = ~sleep_req_i;
      core_busy_i = ($urandom_range(2) == 0);
      irq_i = ($urandom_range(9) == 0) ? (32'h1 << $urandom_range(31)) : 32'h0;
      if ($urandom_range(49) == 0) irq_mask_i = $urandom;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
